tick_divider_bank: RTL and testbench

Bank of NUM_CH independent programmable clock dividers. Each channel produces a one-cycle tick every DIV cycles and a 50% square wave of period 2*DIV. Channels are individually programmable at run time, support periodic and one-shot modes, and can be phase-aligned by a global sync. It is the general timebase for the CPU board (display scan, debounce, UART baud, timers) and generalises the fixed divide-by-500 pulse generator.

---
 rtl/tick_divider_pkg.sv | 19 +
 rtl/tick_divider_ch.sv | 85 ++++++++
 rtl/tick_divider_bank.sv | 53 +++++
 tb/tb_tick_divider_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_divider_pkg.sv
// Shared constants and types for the tick divider bank.
package tick_divider_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int unsigned TDB_WIDTH       = 14;
    localparam int unsigned TDB_DEFAULT_DIV = 500;

    // Storage width of the divisor field. It is wide enough for any WIDTH.
    // Channels only ever load zero-extended WIDTH-bit values into it.
    localparam int unsigned TDB_MAX_WIDTH = 32;

    typedef struct packed {
        logic [TDB_MAX_WIDTH-1:0] div;
        logic                     mode;
    } ch_cfg_t;

endpackage

// File: rtl/tick_divider_ch.sv
// One divider channel: config registers, counter, and tick/sq/done outputs.
module tick_divider_ch
    import tick_divider_pkg::*;
#(
    parameter int unsigned WIDTH       = TDB_WIDTH,
    parameter int unsigned DEFAULT_DIV = TDB_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic             tick,
    output logic             sq,
    output logic             done
);

    ch_cfg_t          cfg_q, cfg_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic active;
    logic terminal;

    // The upper divisor bits are always zero, so a full-width compare equals a WIDTH-bit one.
    // A divisor of zero never reaches the compare, so div-1 cannot underflow.
    always_comb begin
        active   = en && (cfg_q.div != '0) && ((cfg_q.mode == MODE_PERIODIC) || armed_q);
        terminal = active && (TDB_MAX_WIDTH'(count_q) == (cfg_q.div - TDB_MAX_WIDTH'(1)));
    end

    // Next state, in priority order: write, sync, terminal, count.
    always_comb begin
        cfg_d   = cfg_q;
        armed_d = armed_q;
        count_d = count_q;
        tick_d  = 1'b0;
        sq_d    = sq_q;
        if (wr_hit) begin
            cfg_d.div  = TDB_MAX_WIDTH'(wr_div);
            cfg_d.mode = wr_mode;
            armed_d    = 1'b1;
            count_d    = '0;
            sq_d       = 1'b0;
        end else if (sync) begin
            count_d = '0;
        end else if (terminal) begin
            count_d = '0;
            tick_d  = 1'b1;
            sq_d    = ~sq_q;
            if (cfg_q.mode == MODE_ONESHOT) begin
                armed_d = 1'b0;
            end
        end else if (active) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // State register with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q.div  <= TDB_MAX_WIDTH'(DEFAULT_DIV);
            cfg_q.mode <= MODE_PERIODIC;
            armed_q    <= 1'b1;
            count_q    <= '0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            armed_q <= armed_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign done = (cfg_q.mode == MODE_ONESHOT) && !armed_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable tick dividers with a shared write port and sync.
module tick_divider_bank
    import tick_divider_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WIDTH       = TDB_WIDTH,
    parameter int unsigned DEFAULT_DIV = TDB_DEFAULT_DIV,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
    input  logic              wr_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] done
);

    logic [NUM_CH-1:0] wr_hit;

    // Decode the write address; addresses beyond the last channel match nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        tick_divider_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en[g]),
            .sync    (sync),
            .wr_hit  (wr_hit[g]),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .tick    (tick[g]),
            .sq      (sq[g]),
            .done    (done[g])
        );
    end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Randomised and directed bench for tick_divider_bank against a countdown model.
module tb_tick_divider_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [WIDTH-1:0]  wr_div;
    logic              wr_mode;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] done;

    int n_checks = 0;
    int n_errors = 0;

    tick_divider_bank #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (500)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .tick    (tick),
        .sq      (sq),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: each channel counts down the active edges left until its next tick.
    int m_div  [NUM_CH];
    int m_left [NUM_CH];
    bit m_mode [NUM_CH];
    bit m_live [NUM_CH];
    bit m_sq   [NUM_CH];
    bit m_tick [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            m_tick[c] = 1'b0;
            if (reset) begin
                m_div[c]  = 500;
                m_mode[c] = 1'b0;
                m_live[c] = 1'b1;
                m_left[c] = 500;
                m_sq[c]   = 1'b0;
            end else if (wr_en && int'(wr_ch) == c) begin
                m_div[c]  = int'(wr_div);
                m_mode[c] = wr_mode;
                m_live[c] = 1'b1;
                m_left[c] = int'(wr_div);
                m_sq[c]   = 1'b0;
            end else if (sync) begin
                m_left[c] = m_div[c];
            end else if (en[c] && m_div[c] != 0 && (!m_mode[c] || m_live[c])) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_sq[c]   = !m_sq[c];
                    m_left[c] = m_div[c];
                    if (m_mode[c]) m_live[c] = 1'b0;
                end
            end
        end
    endfunction

    task automatic step();
        logic [NUM_CH-1:0] e_tick, e_sq, e_done;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_tick[c] = m_tick[c];
            e_sq[c]   = m_sq[c];
            e_done[c] = m_mode[c] && !m_live[c];
        end
        check("tick", 32'(tick), 32'(e_tick));
        check("sq",   32'(sq),   32'(e_sq));
        check("done", 32'(done), 32'(e_done));
    endtask

    task automatic do_write(input int ch, input int div, input bit mode);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_div  = WIDTH'(div);
        wr_mode = mode;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int first_tick;
        int n_ticks;
        reset   = 1'b1;
        en      = '0;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_mode = 1'b0;
        step();
        step();

        // Defaults: ticks in cycles 500 and 1000 after reset release.
        reset      = 1'b0;
        en         = '1;
        first_tick = 0;
        n_ticks    = 0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            step();
            if (tick[0]) begin
                n_ticks++;
                if (first_tick == 0) first_tick = cyc;
            end
        end
        check("first_tick_cycle", 32'(first_tick), 32'd500);
        check("ticks_in_1000", 32'(n_ticks), 32'd2);

        // Periodic div=3 on ch1.
        do_write(1, 3, 1'b0);
        repeat (12) step();

        // One-shot div=4 on ch2, then rewrite.
        do_write(2, 4, 1'b1);
        repeat (10) step();
        check("oneshot_done", 32'(done[2]), 32'd1);
        do_write(2, 4, 1'b1);
        repeat (10) step();

        // Pause ch3 mid-count.
        do_write(3, 5, 1'b0);
        repeat (2) step();
        en[3] = 1'b0;
        repeat (7) step();
        en[3] = 1'b1;
        repeat (10) step();

        // div=1 then div=0 on ch3.
        do_write(3, 1, 1'b0);
        repeat (5) step();
        check("div1_tick", 32'(tick[3]), 32'd1);
        do_write(3, 0, 1'b0);
        repeat (5) step();
        check("div0_tick", 32'(tick[3]), 32'd0);

        // Sync on ch1's terminal edge suppresses the tick.
        do_write(1, 3, 1'b0);
        repeat (2) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_suppress", 32'(tick[1]), 32'd0);
        repeat (10) step();

        // Reset with a simultaneous write discards the write.
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_div  = WIDTH'(7);
        wr_mode = 1'b1;
        step();
        check("reset_outputs", 32'({tick, sq, done}), 32'd0);
        reset = 1'b0;
        wr_en = 1'b0;
        repeat (505) step();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 599) == 0);
            sync  = ($urandom_range(0, 39) == 0);
            wr_en = ($urandom_range(0, 14) == 0);
            wr_ch = 2'($urandom_range(0, NUM_CH - 1));
            wr_div = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(20, 60))
                                                 : WIDTH'($urandom_range(0, 9));
            wr_mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) begin
                en[c] = ($urandom_range(0, 4) != 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
